alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one registered `alu` instance between NUM_REQ independent requesters, for example several sequencers or cores.
- Accepts at most one operation per cycle using round-robin arbitration and drives the ALU issue port.
- Tracks which requester owns each in-flight operation and returns result, flags and destination to that requester only.
- Sits between the requesters' execute stages and the single ALU; the ALU is not modified.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- REQ_ID_W, 2: requester index width, equal to clog2(NUM_REQ).
- WIDTH, 32: operand and result width, matching the ALU.
- OPCODE, 4: opcode width.
- REGS_CODING, 3: destination register code width.
- FLAGS, 4: flag vector width.
- ALU_LATENCY, 1: issue-to-result latency in cycles of the attached ALU, 1..4; the ALU is fully pipelined.

Ports:
- clk, in, 1: single clock.
- reset, in, 1: synchronous, active-high reset.
- req_valid, in, NUM_REQ: per-requester operation request.
- req_ready, out, NUM_REQ: per-requester grant. Operation i is transferred when req_valid[i] and req_ready[i] are both high at a clk edge.
- req_opcode, in, NUM_REQ*OPCODE: packed opcodes; requester i occupies slice [i*OPCODE +: OPCODE].
- req_op1, in, NUM_REQ*WIDTH: packed first operands.
- req_op2, in, NUM_REQ*WIDTH: packed second operands.
- req_cin, in, NUM_REQ: per-requester carry-in.
- req_dest, in, NUM_REQ*REGS_CODING: packed destination register codes.
- req_lock, in, NUM_REQ: hold grant for the next operation. Used only with ALU_ARB_LOCK_EN.
- alu_en, out, 1: to ALU en.
- alu_opcode, out, OPCODE: to ALU opcode.
- alu_op1, out, WIDTH: to ALU op1.
- alu_op2, out, WIDTH: to ALU op2.
- alu_cin, out, 1: to ALU cin.
- alu_dest, out, REGS_CODING: to ALU dest_in.
- alu_result, in, WIDTH: from ALU result.
- alu_flags, in, FLAGS: from ALU flags.
- alu_dest_out, in, REGS_CODING: from ALU dest_out.
- rsp_valid, out, NUM_REQ: one-hot response strobe.
- rsp_result, out, WIDTH: broadcast result, meaningful only where rsp_valid is set.
- rsp_flags, out, FLAGS: broadcast flags.
- rsp_dest, out, REGS_CODING: broadcast destination code.

Behaviour:

Grant logic (combinational):
- The requester granted is the first i with req_valid[i], searching from rr_ptr upward and wrapping modulo NUM_REQ.
- req_ready is one-hot or zero. It is forced to 0 while reset is high.
- alu_en = |(req_valid & req_ready).
- The alu_* operand outputs mux the granted slices. When nothing is granted they are all 0.

Round-robin pointer (register, REQ_ID_W bits):
- Reset value is 0.
- On a transfer by requester g, rr_ptr <= (g+1) mod NUM_REQ.
- With no transfer, rr_ptr holds.

In-flight tracking:
- A shift register of ALU_LATENCY stages, each holding {vld, id}.
- Stage 0 loads {alu_en, granted id} on every edge; later stages shift each edge.
- All vld bits reset to 0.

Response:
- rsp_valid[id] = vld of the last stage, decoded one-hot.
- rsp_result, rsp_flags and rsp_dest are wired from alu_result, alu_flags and alu_dest_out.
- For a transfer at edge E, rsp_valid is high from E+(ALU_LATENCY-1) to E+ALU_LATENCY, i.e. for exactly one cycle.
- Throughput is one operation per cycle.
- There is no response backpressure; requesters must sample rsp_* while rsp_valid is high.

Reset values:
- req_ready = 0, alu_en = 0, rsp_valid = 0.
- rsp_result, rsp_flags and rsp_dest follow the ALU.

Boundary conditions:
- Reset mid-operation: all in-flight vld bits clear on the same edge; no response is emitted for dropped operations.
- Single requester continuously valid: it is granted every cycle.
- All requesters valid: grant order 0,1,..,NUM_REQ-1,0.
- Requester drops req_valid before a grant: no transfer, pointer unchanged.
- rr_ptr pointing at an idle requester: the search skips it.
- Flags are reported exactly as the ALU computes them. The arbiter never interprets the opcode.

Optional Feature:
- Macro: ALU_ARB_LOCK_EN.
- With the macro, a two-state FSM runs: IDLE and LOCKED(owner).
  - IDLE -> LOCKED(g) on a transfer by g with req_lock[g] = 1.
  - In LOCKED, only the owner may be granted; req_ready of all others is 0.
  - LOCKED -> IDLE on an owner transfer with req_lock = 0.
  - The owner deasserting req_valid while locked keeps the lock.
  - rr_ptr updates only on unlocking transfers.
  - reset forces IDLE.
  - Purpose: atomic multi-word add-with-carry and subtract-with-carry chains.
- Without the macro, req_lock is ignored, no FSM is built, and behaviour is pure round-robin.

Test Plan:
1. After reset, drive req_valid = 4'b0010 with opcode 0000 (add), op1 = 5, op2 = 7, dest = 3 -> req_ready = 4'b0010 in that cycle; one cycle later rsp_valid = 4'b0010, rsp_result = 12, rsp_dest = 3, flags ZERO = 0.
2. Hold req_valid = 4'b1111 for 8 cycles -> grants 0,1,2,3,0,1,2,3; each rsp_valid follows its grant by 1 cycle, one-hot.
3. After granting 2, set req_valid = 4'b0011 -> grants go 0 then 1 (wrap), never 2 or 3.
4. Assert reset the cycle after an issue by requester 1 -> no rsp_valid; req_ready = 0 during reset; first grant after reset comes from pointer 0.
5. With ALU_LATENCY = 3 and back-to-back issues from requesters 0, 1, 2 -> rsp_valid = 0001, 0010, 0100 on consecutive cycles, 3 cycles after each issue.
6. With ALU_ARB_LOCK_EN, requester 1 issues with req_lock = 1 while requesters 0 and 2 are valid -> only requester 1 is granted until it issues with req_lock = 0; requester 2 is granted next.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one pipelined ALU between NUM_REQ requesters.
// Optional ALU_ARB_LOCK_EN macro adds a grant lock for atomic carry chains.
module alu_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int REQ_ID_W    = 2,
    parameter int WIDTH       = 32,
    parameter int OPCODE      = 4,
    parameter int REGS_CODING = 3,
    parameter int FLAGS       = 4,
    parameter int ALU_LATENCY = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*OPCODE-1:0]      req_opcode,
    input  logic [NUM_REQ*WIDTH-1:0]       req_op1,
    input  logic [NUM_REQ*WIDTH-1:0]       req_op2,
    input  logic [NUM_REQ-1:0]             req_cin,
    input  logic [NUM_REQ*REGS_CODING-1:0] req_dest,
    input  logic [NUM_REQ-1:0]             req_lock,
    output logic                           alu_en,
    output logic [OPCODE-1:0]              alu_opcode,
    output logic [WIDTH-1:0]               alu_op1,
    output logic [WIDTH-1:0]               alu_op2,
    output logic                           alu_cin,
    output logic [REGS_CODING-1:0]         alu_dest,
    input  logic [WIDTH-1:0]               alu_result,
    input  logic [FLAGS-1:0]               alu_flags,
    input  logic [REGS_CODING-1:0]         alu_dest_out,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [WIDTH-1:0]               rsp_result,
    output logic [FLAGS-1:0]               rsp_flags,
    output logic [REGS_CODING-1:0]         rsp_dest
);

    logic [NUM_REQ-1:0]  elig;
    logic [REQ_ID_W-1:0] rr_ptr_reg;
    logic [REQ_ID_W-1:0] rr_ptr_next;
    logic [REQ_ID_W-1:0] cand_id [NUM_REQ];
    logic                grant_any;
    logic [REQ_ID_W-1:0] grant_id;
    logic                transfer;
    logic                ptr_advance;

`ifdef ALU_ARB_LOCK_EN
    typedef enum logic {ST_IDLE, ST_LOCKED} lock_state_t;
    lock_state_t         state_reg;
    logic [REQ_ID_W-1:0] owner_reg;

    always_comb begin
        elig = req_valid;
        if (state_reg == ST_LOCKED)
            elig = req_valid & (NUM_REQ'(1) << owner_reg);
    end

    // The pointer only moves once a chain is released, so lock holders keep priority.
    assign ptr_advance = transfer && !req_lock[grant_id];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            owner_reg <= '0;
        end else if (transfer) begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_lock[grant_id]) begin
                        state_reg <= ST_LOCKED;
                        owner_reg <= grant_id;
                    end
                end
                ST_LOCKED: begin
                    if (!req_lock[grant_id])
                        state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;
    assign elig        = req_valid;
    assign ptr_advance = transfer;
`endif

    // cand_id[k] is the k-th requester visited when searching from rr_ptr.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            logic [REQ_ID_W:0] sum;
            assign sum = {1'b0, rr_ptr_reg} + (REQ_ID_W+1)'(gi);
            assign cand_id[gi] = (sum >= (REQ_ID_W+1)'(NUM_REQ))
                               ? REQ_ID_W'(sum - (REQ_ID_W+1)'(NUM_REQ))
                               : sum[REQ_ID_W-1:0];
        end
    endgenerate

    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (elig[cand_id[k]]) begin
                grant_any = 1'b1;
                grant_id  = cand_id[k];
            end
        end
    end

    assign req_ready = (grant_any && !reset) ? (NUM_REQ'(1) << grant_id) : '0;
    assign transfer  = |(req_valid & req_ready);
    assign alu_en    = transfer;

    always_comb begin
        alu_opcode = '0;
        alu_op1    = '0;
        alu_op2    = '0;
        alu_cin    = 1'b0;
        alu_dest   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_valid[k] && req_ready[k]) begin
                alu_opcode = req_opcode[k*OPCODE +: OPCODE];
                alu_op1    = req_op1[k*WIDTH +: WIDTH];
                alu_op2    = req_op2[k*WIDTH +: WIDTH];
                alu_cin    = req_cin[k];
                alu_dest   = req_dest[k*REGS_CODING +: REGS_CODING];
            end
        end
    end

    assign rr_ptr_next = (grant_id == REQ_ID_W'(NUM_REQ - 1)) ? '0 : grant_id + REQ_ID_W'(1);

    always_ff @(posedge clk) begin
        if (reset)
            rr_ptr_reg <= '0;
        else if (ptr_advance)
            rr_ptr_reg <= rr_ptr_next;
    end

    // In-flight ownership tracking, aligned with the ALU pipeline depth.
    logic                vld_reg [ALU_LATENCY];
    logic [REQ_ID_W-1:0] id_reg  [ALU_LATENCY];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < ALU_LATENCY; s++)
                vld_reg[s] <= 1'b0;
        end else begin
            vld_reg[0] <= transfer;
            for (int s = 1; s < ALU_LATENCY; s++)
                vld_reg[s] <= vld_reg[s-1];
        end
    end

    always_ff @(posedge clk) begin
        id_reg[0] <= grant_id;
        for (int s = 1; s < ALU_LATENCY; s++)
            id_reg[s] <= id_reg[s-1];
    end

    assign rsp_valid  = (vld_reg[ALU_LATENCY-1] && !reset)
                      ? (NUM_REQ'(1) << id_reg[ALU_LATENCY-1]) : '0;
    assign rsp_result = alu_result;
    assign rsp_flags  = alu_flags;
    assign rsp_dest   = alu_dest_out;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (ALU latency 1 and 3) share stimulus and
// are checked cycle by cycle against a queue-level arbitration model.
module tb_alu_arbiter;

    localparam int N = 4;

    logic         clk;
    logic         reset;
    logic [3:0]   req_valid;
    logic [15:0]  req_opcode;
    logic [127:0] req_op1;
    logic [127:0] req_op2;
    logic [3:0]   req_cin;
    logic [11:0]  req_dest;
    logic [3:0]   req_lock;

    logic [3:0]  req_ready1, r1_valid, req_ready3, r3_valid;
    logic        a1_en, a1_cin, a3_en, a3_cin;
    logic [3:0]  a1_opcode, a3_opcode, r1_flags, r3_flags;
    logic [31:0] a1_op1, a1_op2, a3_op1, a3_op2, r1_result, r3_result;
    logic [2:0]  a1_dest, a3_dest, r1_dest, r3_dest;

    logic [31:0] p1_res;
    logic [3:0]  p1_fl;
    logic [2:0]  p1_dst;
    logic [31:0] p3_res [3];
    logic [3:0]  p3_fl  [3];
    logic [2:0]  p3_dst [3];

    int vectors;
    int miscompares;

    // Reference model state
    int          m_ptr;
    logic        m_locked;
    int          m_owner;
    logic        e1_vld;
    int          e1_id;
    logic [38:0] e1_dat;
    logic        e3_vld [3];
    int          e3_id  [3];
    logic [38:0] e3_dat [3];

    logic [3:0]  obs_ready1, obs_ready3, obs_rsp1, obs_rsp3;
    logic [31:0] obs_res1;
    logic [3:0]  obs_flags1;
    logic [2:0]  obs_dest1;

    alu_arbiter #(.ALU_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready1),
        .req_opcode(req_opcode), .req_op1(req_op1), .req_op2(req_op2), .req_cin(req_cin),
        .req_dest(req_dest), .req_lock(req_lock),
        .alu_en(a1_en), .alu_opcode(a1_opcode), .alu_op1(a1_op1), .alu_op2(a1_op2),
        .alu_cin(a1_cin), .alu_dest(a1_dest),
        .alu_result(p1_res), .alu_flags(p1_fl), .alu_dest_out(p1_dst),
        .rsp_valid(r1_valid), .rsp_result(r1_result), .rsp_flags(r1_flags), .rsp_dest(r1_dest)
    );

    alu_arbiter #(.ALU_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready3),
        .req_opcode(req_opcode), .req_op1(req_op1), .req_op2(req_op2), .req_cin(req_cin),
        .req_dest(req_dest), .req_lock(req_lock),
        .alu_en(a3_en), .alu_opcode(a3_opcode), .alu_op1(a3_op1), .alu_op2(a3_op2),
        .alu_cin(a3_cin), .alu_dest(a3_dest),
        .alu_result(p3_res[2]), .alu_flags(p3_fl[2]), .alu_dest_out(p3_dst[2]),
        .rsp_valid(r3_valid), .rsp_result(r3_result), .rsp_flags(r3_flags), .rsp_dest(r3_dest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {flags[3:0] = {ovf, neg, carry, zero}, result[31:0]}
    function automatic logic [35:0] alu_fn(input logic [3:0] opc, input logic [31:0] a,
                                           input logic [31:0] b, input logic cin);
        logic [32:0] s;
        logic [31:0] r;
        logic        c;
        logic        v;
        s = '0; r = '0; c = 1'b0; v = 1'b0;
        case (opc)
            4'd0: begin
                s = {1'b0, a} + {1'b0, b} + {32'd0, cin};
                r = s[31:0]; c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'd1: begin
                s = {1'b0, a} + {1'b0, ~b} + {32'd0, cin};
                r = s[31:0]; c = s[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            default: r = a << b[4:0];
        endcase
        return {v, r[31], c, (r == 32'd0), r};
    endfunction

    // Stand-in registered ALUs of depth 1 and 3.
    always @(posedge clk) begin
        {p1_fl, p1_res} <= alu_fn(a1_opcode, a1_op1, a1_op2, a1_cin);
        p1_dst          <= a1_dest;
        {p3_fl[0], p3_res[0]} <= alu_fn(a3_opcode, a3_op1, a3_op2, a3_cin);
        p3_dst[0] <= a3_dest;
        for (int s = 1; s < 3; s++) begin
            p3_res[s] <= p3_res[s-1];
            p3_fl[s]  <= p3_fl[s-1];
            p3_dst[s] <= p3_dst[s-1];
        end
    end

    task automatic model_grant(output logic any, output int g);
        any = 1'b0;
        g   = 0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (!any && req_valid[idx] && (!m_locked || idx == m_owner)) begin
                any = 1'b1;
                g   = idx;
            end
        end
    endtask

    task automatic randomize_operands();
        for (int i = 0; i < N; i++) begin
            req_opcode[i*4 +: 4] = 4'($urandom_range(0, 5));
            req_op1[i*32 +: 32]  = $urandom;
            req_op2[i*32 +: 32]  = $urandom;
            req_dest[i*3 +: 3]   = 3'($urandom);
        end
        req_cin = 4'($urandom);
    endtask

    // One clock of stimulus: check every output against the model, then advance it.
    task automatic run_cycle();
        logic        g_any;
        int          g;
        logic [3:0]  exp_ready;
        logic [3:0]  exp_rsp;
        logic [38:0] dat;
        #1;
        model_grant(g_any, g);
        if (reset) g_any = 1'b0;
        exp_ready = g_any ? (4'b0001 << g) : 4'b0000;
        dat = g_any ? {req_dest[g*3 +: 3], alu_fn(req_opcode[g*4 +: 4], req_op1[g*32 +: 32],
                                                  req_op2[g*32 +: 32], req_cin[g])} : 39'd0;
        obs_ready1 = req_ready1; obs_ready3 = req_ready3;
        obs_rsp1 = r1_valid; obs_rsp3 = r3_valid;
        obs_res1 = r1_result; obs_flags1 = r1_flags; obs_dest1 = r1_dest;

        vectors++;
        if (req_ready1 !== exp_ready) begin
            miscompares++;
            $display("FAIL ready_lat1: got %b want %b at %0t", req_ready1, exp_ready, $time);
        end
        vectors++;
        if (req_ready3 !== exp_ready) begin
            miscompares++;
            $display("FAIL ready_lat3: got %b want %b at %0t", req_ready3, exp_ready, $time);
        end
        vectors++;
        if (a1_en !== g_any || a3_en !== g_any) begin
            miscompares++;
            $display("FAIL alu_en: got %b/%b want %b at %0t", a1_en, a3_en, g_any, $time);
        end
        vectors++;
        if (g_any && ({a1_opcode, a1_op1, a1_op2, a1_cin, a1_dest} !==
                      {req_opcode[g*4 +: 4], req_op1[g*32 +: 32], req_op2[g*32 +: 32],
                       req_cin[g], req_dest[g*3 +: 3]})) begin
            miscompares++;
            $display("FAIL issue_mux: got op %h a %h b %h want op %h a %h b %h at %0t",
                     a1_opcode, a1_op1, a1_op2, req_opcode[g*4 +: 4], req_op1[g*32 +: 32],
                     req_op2[g*32 +: 32], $time);
        end else if (!g_any && ({a1_opcode, a1_op1, a1_op2, a1_cin, a1_dest} !== 72'd0)) begin
            miscompares++;
            $display("FAIL issue_idle: got op %h a %h b %h want zeros at %0t",
                     a1_opcode, a1_op1, a1_op2, $time);
        end

        exp_rsp = (!reset && e1_vld) ? (4'b0001 << e1_id) : 4'b0000;
        vectors++;
        if (r1_valid !== exp_rsp) begin
            miscompares++;
            $display("FAIL rsp_valid_lat1: got %b want %b at %0t", r1_valid, exp_rsp, $time);
        end else if (exp_rsp != 4'b0000 && {r1_dest, r1_flags, r1_result} !== e1_dat) begin
            miscompares++;
            $display("FAIL rsp_data_lat1: got %h want %h at %0t",
                     {r1_dest, r1_flags, r1_result}, e1_dat, $time);
        end
        exp_rsp = (!reset && e3_vld[2]) ? (4'b0001 << e3_id[2]) : 4'b0000;
        vectors++;
        if (r3_valid !== exp_rsp) begin
            miscompares++;
            $display("FAIL rsp_valid_lat3: got %b want %b at %0t", r3_valid, exp_rsp, $time);
        end else if (exp_rsp != 4'b0000 && {r3_dest, r3_flags, r3_result} !== e3_dat[2]) begin
            miscompares++;
            $display("FAIL rsp_data_lat3: got %h want %h at %0t",
                     {r3_dest, r3_flags, r3_result}, e3_dat[2], $time);
        end

        if (g_any)
            $display("t=%0t issue req %0d opcode %0d dest %0d", $time, g,
                     req_opcode[g*4 +: 4], req_dest[g*3 +: 3]);

        @(posedge clk);
        if (reset) begin
            m_ptr = 0; m_locked = 1'b0; m_owner = 0;
            e1_vld = 1'b0;
            for (int s = 0; s < 3; s++) e3_vld[s] = 1'b0;
        end else begin
            for (int s = 2; s > 0; s--) begin
                e3_vld[s] = e3_vld[s-1]; e3_id[s] = e3_id[s-1]; e3_dat[s] = e3_dat[s-1];
            end
            e3_vld[0] = g_any; e3_id[0] = g; e3_dat[0] = dat;
            e1_vld = g_any; e1_id = g; e1_dat = dat;
            if (g_any) begin
`ifdef ALU_ARB_LOCK_EN
                if (!m_locked && req_lock[g]) begin
                    m_locked = 1'b1; m_owner = g;
                end else if (m_locked && !req_lock[g]) begin
                    m_locked = 1'b0;
                end
                if (!req_lock[g]) m_ptr = (g + 1) % N;
`else
                m_ptr = (g + 1) % N;
`endif
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 4'b1111;
        randomize_operands();
        run_cycle();
        run_cycle();
        vectors++;
        if (obs_ready1 !== 4'b0000 || obs_rsp1 !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_state: ready %b rsp %b want 0000 0000", obs_ready1, obs_rsp1);
        end
    endtask

    task automatic test_single();
        reset = 1'b0;
        req_valid = 4'b0010;
        req_opcode[4 +: 4] = 4'd0;
        req_op1[32 +: 32] = 32'd5;
        req_op2[32 +: 32] = 32'd7;
        req_cin[1] = 1'b0;
        req_dest[3 +: 3] = 3'd3;
        run_cycle();
        vectors++;
        if (obs_ready1 !== 4'b0010) begin
            miscompares++;
            $display("FAIL single_grant: got %b want 0010", obs_ready1);
        end
        req_valid = 4'b0000;
        run_cycle();
        vectors++;
        if (obs_rsp1 !== 4'b0010 || obs_res1 !== 32'd12 || obs_dest1 !== 3'd3 || obs_flags1[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL single_rsp: got v %b r %0d d %0d z %b want 0010 12 3 0",
                     obs_rsp1, obs_res1, obs_dest1, obs_flags1[0]);
        end
        req_valid = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            randomize_operands();
            run_cycle();
            vectors++;
            if (obs_ready1 !== 4'b0100) begin
                miscompares++;
                $display("FAIL continuous_single: cycle %0d got %b want 0100", k, obs_ready1);
            end
        end
    endtask

    task automatic test_all_valid();
        reset = 1'b1;
        run_cycle();
        reset = 1'b0;
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            logic [3:0] want;
            want = 4'b0001 << (k % 4);
            randomize_operands();
            run_cycle();
            vectors++;
            if (obs_ready1 !== want) begin
                miscompares++;
                $display("FAIL rr_order: step %0d got %b want %b", k, obs_ready1, want);
            end
        end
    endtask

    task automatic test_wrap();
        logic [3:0] want [3];
        want[0] = 4'b0001; want[1] = 4'b0010; want[2] = 4'b0001;
        req_valid = 4'b1111;
        for (int k = 0; k < 3; k++) run_cycle();
        req_valid = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            run_cycle();
            vectors++;
            if (obs_ready1 !== want[k]) begin
                miscompares++;
                $display("FAIL wrap_skip: step %0d got %b want %b", k, obs_ready1, want[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        run_cycle();
        reset = 1'b0;
        req_valid = 4'b0010;
        run_cycle();
        reset = 1'b1;
        req_valid = 4'b1111;
        run_cycle();
        vectors++;
        if (obs_rsp1 !== 4'b0000 || obs_ready1 !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_mid: rsp %b ready %b want 0000 0000", obs_rsp1, obs_ready1);
        end
        run_cycle();
        reset = 1'b0;
        run_cycle();
        vectors++;
        if (obs_ready1 !== 4'b0001 || obs_rsp3 !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_recover: ready %b rsp3 %b want 0001 0000", obs_ready1, obs_rsp3);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] rsp3_log [7];
        logic [3:0] rsp1_log [7];
        reset = 1'b1;
        run_cycle();
        reset = 1'b0;
        for (int k = 0; k < 7; k++) begin
            req_valid = (k < 3) ? 4'b0111 : 4'b0000;
            randomize_operands();
            run_cycle();
            rsp3_log[k] = obs_rsp3;
            rsp1_log[k] = obs_rsp1;
        end
        vectors++;
        if (rsp3_log[3] !== 4'b0001 || rsp3_log[4] !== 4'b0010 || rsp3_log[5] !== 4'b0100 ||
            rsp3_log[6] !== 4'b0000) begin
            miscompares++;
            $display("FAIL b2b_lat3: got %b %b %b %b want 0001 0010 0100 0000",
                     rsp3_log[3], rsp3_log[4], rsp3_log[5], rsp3_log[6]);
        end
        vectors++;
        if (rsp1_log[1] !== 4'b0001 || rsp1_log[2] !== 4'b0010 || rsp1_log[3] !== 4'b0100) begin
            miscompares++;
            $display("FAIL b2b_lat1: got %b %b %b want 0001 0010 0100",
                     rsp1_log[1], rsp1_log[2], rsp1_log[3]);
        end
    endtask

`ifdef ALU_ARB_LOCK_EN
    task automatic test_lock();
        logic [3:0] want [8];
        want[0] = 4'b0001; want[1] = 4'b0010; want[2] = 4'b0010; want[3] = 4'b0010;
        want[4] = 4'b0010; want[5] = 4'b0000; want[6] = 4'b0010; want[7] = 4'b0100;
        reset = 1'b1;
        req_lock = 4'b0000;
        run_cycle();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            req_valid = (k == 5) ? 4'b0101 : 4'b0111;
            req_lock  = (k >= 6) ? 4'b0000 : 4'b0010;
            randomize_operands();
            run_cycle();
            vectors++;
            if (obs_ready1 !== want[k]) begin
                miscompares++;
                $display("FAIL lock_grant: step %0d got %b want %b", k, obs_ready1, want[k]);
            end
        end
        req_lock = 4'b0000;
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            reset     = ($urandom_range(0, 39) == 0);
            req_valid = 4'($urandom);
            req_lock  = 4'($urandom) & 4'($urandom);
            randomize_operands();
            run_cycle();
        end
        reset = 1'b0;
        req_lock = 4'b0000;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        m_ptr = 0; m_locked = 1'b0; m_owner = 0;
        e1_vld = 1'b0; e1_id = 0; e1_dat = '0;
        for (int s = 0; s < 3; s++) begin
            e3_vld[s] = 1'b0; e3_id[s] = 0; e3_dat[s] = '0;
        end
        reset = 1'b1;
        req_valid = '0; req_opcode = '0; req_op1 = '0; req_op2 = '0;
        req_cin = '0; req_dest = '0; req_lock = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_all_valid();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
`ifdef ALU_ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
